// File: rtl/spi_sample_sched.sv
// Periodic sampling scheduler: runs one SPI transaction per converter channel each sample period
// and publishes the whole frame at once. Optional transaction watchdog: define SCHED_TIMEOUT_EN.
module spi_sample_sched #(
    parameter int BITS           = 4,
    parameter int NCH            = 2,
    parameter int PERIOD_BITS    = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [PERIOD_BITS-1:0] period,
    output logic                   spi_start,
    input  logic                   spi_cs,
    input  logic [BITS-1:0]        spi_data,
    output logic                   spi_miso,
    input  logic [NCH-1:0]         dev_miso,
    output logic [NCH-1:0]         dev_cs,
    output logic [NCH*BITS-1:0]    sample_data,
    output logic                   sample_valid,
    output logic                   overrun,
    output logic                   err
);

    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_LOW,
        WAIT_HIGH,
        DONE
    } state_t;

    state_t                 state;
    logic [CH_W-1:0]        ch;
    logic [PERIOD_BITS-1:0] timer;
    logic                   tick;
    logic [NCH*BITS-1:0]    shadow;
    logic [NCH*BITS-1:0]    shadow_next;

`ifdef SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd;
`endif

    // Sample timebase: compare against the live period so a new value applies at the next compare.
    assign tick = (period != '0) && (timer == (period - PERIOD_BITS'(1)));

    always_ff @(posedge clk) begin
        if (reset) begin
            timer <= '0;
        end else if (period == '0 || tick) begin
            timer <= '0;
        end else begin
            timer <= timer + PERIOD_BITS'(1);
        end
    end

    always_comb begin
        shadow_next = shadow;
        shadow_next[ch*BITS +: BITS] = spi_data;
    end

    // Results land in sample_data on entry to DONE, so data and valid are both visible during DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            ch           <= '0;
            spi_start    <= 1'b0;
            sample_valid <= 1'b0;
            sample_data  <= '0;
            overrun      <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
            wd           <= '0;
            err          <= 1'b0;
`endif
        end else begin
            spi_start    <= 1'b0;
            sample_valid <= 1'b0;
            if (tick && state != IDLE) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (tick) begin
                        ch        <= '0;
                        spi_start <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    state <= WAIT_LOW;
                end
                WAIT_LOW: begin
                    if (!spi_cs) begin
                        state <= WAIT_HIGH;
                    end
                end
                WAIT_HIGH: begin
                    if (spi_cs) begin
                        shadow <= shadow_next;
                        if (ch == CH_W'(NCH - 1)) begin
                            sample_data  <= shadow_next;
                            sample_valid <= 1'b1;
                            state        <= DONE;
                        end else begin
                            ch        <= ch + 1'b1;
                            spi_start <= 1'b1;
                            state     <= START;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
`ifdef SCHED_TIMEOUT_EN
            // Watchdog overrides whatever the FSM decided this cycle and abandons the frame.
            if (state == START) begin
                wd <= '0;
            end else if (state == WAIT_LOW || state == WAIT_HIGH) begin
                if (wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    state        <= IDLE;
                    ch           <= '0;
                    spi_start    <= 1'b0;
                    sample_valid <= 1'b0;
                    sample_data  <= sample_data;
                    err          <= 1'b1;
                end else begin
                    wd <= wd + 1'b1;
                end
            end
`endif
        end
    end

`ifndef SCHED_TIMEOUT_EN
    assign err = 1'b0;
`endif

    always_comb begin
        dev_cs = '1;
        if (state != IDLE) begin
            dev_cs[ch] = spi_cs;
        end
    end

    assign spi_miso = dev_miso[ch];

endmodule
